// File: rtl/clock_window_accumulator.sv
// ============================================================================
//  Module   : clock_window_accumulator
//  Purpose  : Sums valid signed samples between selected slow_clk edges and
//             hands each window (sum/count/sat) to a valid/ready buffer.
//             Define CWA_SKID_EN for a 2-entry output FIFO instead of 1 entry.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module clock_window_accumulator #(
   parameter int DW    = 14,
   parameter int ACC_W = 32,
   parameter int CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    slow_clk,
   input  logic [1:0]              edge_mode,
   input  logic signed [DW-1:0]    din,
   input  logic                    din_valid,
   output logic signed [ACC_W-1:0] sum_out,
   output logic [CNT_W-1:0]        cnt_out,
   output logic                    sat_out,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    overrun,
   input  logic                    clear_overrun
);

   localparam int EW = ACC_W + CNT_W + 1;
   localparam logic [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_ACCUM = 2'd2
   } state_t;

   state_t             state_q;
   logic               slow_q;
   logic [ACC_W-1:0]   acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               sat_q;
   logic               overrun_q;

   logic               w_rise, w_fall, w_bnd, w_disable;
   logic [ACC_W-1:0]   w_din_ext;
   logic [ACC_W:0]     w_sum_ext;
   logic               w_ovf;
   logic [ACC_W-1:0]   w_acc_add;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic               w_push, w_pop, w_drop;
   logic [EW-1:0]      w_win;

   assign w_rise    = slow_clk & ~slow_q;
   assign w_fall    = ~slow_clk & slow_q;
   assign w_disable = (edge_mode == 2'b11);

   always_comb begin
      w_bnd = 1'b0;
      case (edge_mode)
         2'b00:   w_bnd = w_rise;
         2'b01:   w_bnd = w_fall;
         2'b10:   w_bnd = w_rise | w_fall;
         default: w_bnd = 1'b0;
      endcase
   end

   // One guard bit exposes signed overflow; clamp toward the sign of the true sum.
   assign w_din_ext = {{(ACC_W-DW){din[DW-1]}}, din};
   assign w_sum_ext = {acc_q[ACC_W-1], acc_q} + {w_din_ext[ACC_W-1], w_din_ext};
   assign w_ovf     = w_sum_ext[ACC_W] ^ w_sum_ext[ACC_W-1];
   assign w_acc_add = w_ovf ? (w_sum_ext[ACC_W] ? c_acc_min : c_acc_max)
                            : w_sum_ext[ACC_W-1:0];
   assign w_cnt_inc = (&cnt_q) ? cnt_q : cnt_q + c_cnt_one;

   assign w_push = (state_q == S_ACCUM) & ~w_disable & w_bnd;
   assign w_win  = {sat_q, cnt_q, acc_q};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         slow_q  <= 1'b0;
         acc_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         slow_q <= slow_clk;
         case (state_q)
            S_IDLE: begin
               acc_q <= '0;
               cnt_q <= '0;
               sat_q <= 1'b0;
               if (!w_disable) state_q <= S_ARM;
            end
            S_ARM, S_ACCUM: begin
               if (w_disable) begin
                  state_q <= S_IDLE;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  sat_q   <= 1'b0;
               end else if (w_bnd) begin
                  // The boundary sample opens the next window.
                  state_q <= S_ACCUM;
                  acc_q   <= din_valid ? w_din_ext : '0;
                  cnt_q   <= din_valid ? c_cnt_one : '0;
                  sat_q   <= 1'b0;
               end else if (state_q == S_ACCUM && din_valid) begin
                  acc_q <= w_acc_add;
                  cnt_q <= w_cnt_inc;
                  sat_q <= sat_q | w_ovf;
               end
            end
            default: begin
               state_q <= S_IDLE;
               acc_q   <= '0;
               cnt_q   <= '0;
               sat_q   <= 1'b0;
            end
         endcase
      end
   end

`ifdef CWA_SKID_EN
   logic [EW-1:0] ent0_q, ent1_q;
   logic [1:0]    fill_q;

   assign w_pop  = (fill_q != 2'd0) & out_ready;
   assign w_drop = w_push & ~w_pop & (fill_q == 2'd2);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ent0_q <= '0;
         ent1_q <= '0;
         fill_q <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b11: begin
               if (fill_q == 2'd1) begin
                  ent0_q <= w_win;
               end else begin
                  ent0_q <= ent1_q;
                  ent1_q <= w_win;
               end
            end
            2'b01: begin
               ent0_q <= ent1_q;
               fill_q <= fill_q - 2'd1;
            end
            2'b10: begin
               if (fill_q == 2'd0) begin
                  ent0_q <= w_win;
                  fill_q <= 2'd1;
               end else if (fill_q == 2'd1) begin
                  ent1_q <= w_win;
                  fill_q <= 2'd2;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid = (fill_q != 2'd0);
   assign {sat_out, cnt_out, sum_out} = ent0_q;
`else
   logic [EW-1:0] ent_q;
   logic          valid_q;

   assign w_pop  = valid_q & out_ready;
   assign w_drop = w_push & valid_q & ~w_pop;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ent_q   <= '0;
         valid_q <= 1'b0;
      end else if (w_push && (!valid_q || w_pop)) begin
         ent_q   <= w_win;
         valid_q <= 1'b1;
      end else if (w_pop) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid = valid_q;
   assign {sat_out, cnt_out, sum_out} = ent_q;
`endif

   // A new drop outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!rst_n)             overrun_q <= 1'b0;
      else if (w_drop)        overrun_q <= 1'b1;
      else if (clear_overrun) overrun_q <= 1'b0;
   end

   assign overrun = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_window_accumulator.sv
// ============================================================================
//  Module   : tb_clock_window_accumulator
//  Purpose  : Directed self-checking bench for clock_window_accumulator
//             (ACC_W = 16 so saturation is reachable with 14-bit samples).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_clock_window_accumulator;

   logic               clk;
   logic               rst_n;
   logic               slow_clk;
   logic [1:0]         edge_mode;
   logic signed [13:0] din;
   logic               din_valid;
   logic signed [15:0] sum_out;
   logic [31:0]        cnt_out;
   logic               sat_out;
   logic               out_valid;
   logic               out_ready;
   logic               overrun;
   logic               clear_overrun;

   int n_cmp = 0;
   int n_err = 0;

   logic               s_valid, s_sat, s_ovr;
   logic signed [15:0] s_sum;
   logic [31:0]        s_cnt;
   int                 seen;

   clock_window_accumulator #(.DW(14), .ACC_W(16), .CNT_W(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .slow_clk      (slow_clk),
      .edge_mode     (edge_mode),
      .din           (din),
      .din_valid     (din_valid),
      .sum_out       (sum_out),
      .cnt_out       (cnt_out),
      .sat_out       (sat_out),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .overrun       (overrun),
      .clear_overrun (clear_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Hold slow_clk at lvl for n cycles; din_valid drops for the last 'off' cycles.
   // Outputs right after the first (possible boundary) cycle are snapshotted.
   task automatic seg(input logic lvl, input int n, input int off);
      for (int i = 0; i < n; i++) begin
         slow_clk  = lvl;
         din_valid = (i < n - off);
         @(posedge clk);
         #1;
         if (i == 0) begin
            s_valid = out_valid;
            s_sum   = sum_out;
            s_cnt   = cnt_out;
            s_sat   = sat_out;
            s_ovr   = overrun;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; slow_clk = 1'b0; edge_mode = 2'b00; din = 14'sd100;
      din_valid = 1'b1; out_ready = 1'b1; clear_overrun = 1'b0;

      seg(0, 2, 0);
      chk("rst_valid",   out_valid, 0);
      chk("rst_sum",     sum_out,   0);
      chk("rst_cnt",     cnt_out,   0);
      chk("rst_sat",     sat_out,   0);
      chk("rst_overrun", overrun,   0);
      rst_n = 1'b1;

      // Rising mode
      seg(0, 5, 0);
      seg(1, 5, 0);
      chk("rise_arm_no_valid", s_valid, 0);
      seg(0, 5, 0);
      seg(1, 5, 0);
      chk("rise_valid", s_valid, 1);
      chk("rise_sum",   s_sum,   1000);
      chk("rise_cnt",   s_cnt,   10);
      chk("rise_sat",   s_sat,   0);
      chk("rise_popped", out_valid, 0);
      seg(0, 5, 0);
      seg(1, 5, 0);
      chk("rise2_sum", s_sum, 1000);
      chk("rise2_cnt", s_cnt, 10);

      // Both-edges mode
      edge_mode = 2'b10;
      seg(0, 5, 0);
      chk("both_fall_valid", s_valid, 1);
      chk("both_fall_sum",   s_sum,   500);
      chk("both_fall_cnt",   s_cnt,   5);
      seg(1, 5, 0);
      chk("both_rise_sum", s_sum, 500);
      chk("both_rise_cnt", s_cnt, 5);
      seg(0, 5, 2);
      seg(1, 5, 2);
      chk("gap_sum", s_sum, 300);
      chk("gap_cnt", s_cnt, 3);

      // Saturation
      din = 14'sd8191;
      seg(0, 10, 0);
      seg(1, 10, 0);
      chk("satp_sum", s_sum, 32767);
      chk("satp_cnt", s_cnt, 10);
      chk("satp_sat", s_sat, 1);
      din = -14'sd8192;
      seg(0, 10, 0);
      seg(1, 10, 0);
      chk("satn_sum", s_sum, -32768);
      chk("satn_cnt", s_cnt, 10);
      chk("satn_sat", s_sat, 1);
      din = 14'sd100;
      seg(0, 5, 0);
      seg(1, 5, 0);
      chk("nosat_sum", s_sum, 500);
      chk("nosat_sat", s_sat, 0);

      // Overrun
      out_ready = 1'b0;
      din = 14'sd7;
`ifdef CWA_SKID_EN
      seg(0, 5, 0);
      din = 14'sd9;
      seg(1, 5, 0);
      chk("skid_two_no_ovr", s_ovr, 0);
      chk("skid_two_valid",  s_valid, 1);
      seg(0, 5, 0);
      chk("ovr_set",  s_ovr, 1);
      chk("ovr_held_sum", s_sum, 500);
      chk("ovr_held_cnt", s_cnt, 5);
      clear_overrun = 1'b1;
      seg(0, 1, 0);
      clear_overrun = 1'b0;
      chk("ovr_clear", overrun, 0);
      out_ready = 1'b1;
      seg(0, 1, 0);
      chk("skid_drain2_valid", out_valid, 1);
      chk("skid_drain2_sum",   sum_out,   35);
      seg(0, 1, 0);
      chk("skid_empty", out_valid, 0);
`else
      seg(0, 5, 0);
      seg(1, 5, 0);
      chk("ovr_set",      s_ovr,   1);
      chk("ovr_valid",    s_valid, 1);
      chk("ovr_held_sum", s_sum,   500);
      chk("ovr_held_cnt", s_cnt,   5);
      clear_overrun = 1'b1;
      seg(1, 1, 0);
      clear_overrun = 1'b0;
      chk("ovr_clear",      overrun, 0);
      chk("ovr_still_held", sum_out, 500);
      out_ready = 1'b1;
      seg(1, 1, 0);
      chk("ovr_popped", out_valid, 0);
`endif

      // Reset mid-window
      edge_mode = 2'b00;
      din = 14'sd100;
      rst_n = 1'b0;
      seg(0, 1, 0);
      chk("mrst_valid", out_valid, 0);
      chk("mrst_sum",   sum_out,   0);
      chk("mrst_cnt",   cnt_out,   0);
      chk("mrst_sat",   sat_out,   0);
      chk("mrst_ovr",   overrun,   0);
      rst_n = 1'b1;
      seg(0, 3, 0);
      seg(1, 5, 0);
      chk("mrst_arm_no_valid", s_valid, 0);
      seg(0, 5, 0);
      chk("mrst_still_empty", out_valid, 0);
      seg(1, 5, 0);
      chk("mrst_win_valid", s_valid, 1);
      chk("mrst_win_sum",   s_sum,   1000);

      // Disable mid-window
      edge_mode = 2'b11;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         slow_clk  = (((i / 5) % 2) == 0) ? 1'b0 : 1'b1;
         din_valid = 1'b1;
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      chk("dis_no_valid", seen, 0);
      edge_mode = 2'b00;
      seg(0, 5, 0);
      seg(1, 5, 0);
      chk("dis_rearm_no_valid", s_valid, 0);
      seg(0, 5, 0);
      seg(1, 5, 0);
      chk("dis_win_valid", s_valid, 1);
      chk("dis_win_sum",   s_sum,   1000);
      chk("dis_win_cnt",   s_cnt,   10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
